// File: rtl/mem_rd_arbiter.sv
// Read-channel arbiter: shares one AXI AR/R channel between i-side and d-side refills, one burst at a time.
// Define ARB_RR_EN for round-robin arbitration on contention; default is fixed priority, d over i.
module mem_rd_arbiter #(
  parameter logic [3:0] I_ID = 4'd0,
  parameter logic [3:0] D_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  output logic        i_ack,
  output logic        i_rvalid,
  output logic        i_rlast,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [7:0]  d_len,
  output logic        d_ack,
  output logic        d_rvalid,
  output logic        d_rlast,
  output logic [31:0] rdata_o,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  // Handshakes: an AR transfer happens on a cycle with arvalid && arready; an R beat
  // is consumed on every cycle with rvalid && rready. rready is held high for the
  // whole DATA phase, so beats are never back-pressured and requesters must sink them.
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state_q, state_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        owner_is_d_q, owner_is_d_d;

  logic grant_d;
  logic grant_i;
  logic beat_match;
  logic unused_rresp;

`ifdef ARB_RR_EN
  // last_grant: 1 = d-side won the previous grant.
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant_d = d_req && (!i_req || !last_grant_q);
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  always_comb begin
    grant_i    = i_req && !grant_d;
    beat_match = (state_q == DATA) && rvalid && (rid == arid_q);
  end

  assign i_ack    = (state_q == IDLE) && grant_i;
  assign d_ack    = (state_q == IDLE) && grant_d;
  assign i_rvalid = beat_match && !owner_is_d_q;
  assign d_rvalid = beat_match && owner_is_d_q;
  assign i_rlast  = i_rvalid && rlast;
  assign d_rlast  = d_rvalid && rlast;
  assign rdata_o  = rdata;

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign unused_rresp = ^rresp;

  always_comb begin
    state_d      = state_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    owner_is_d_d = owner_is_d_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d || grant_i) begin
          arid_d       = grant_d ? D_ID : I_ID;
          araddr_d     = grant_d ? d_addr : i_addr;
          arlen_d      = grant_d ? d_len : i_len;
          owner_is_d_d = grant_d;
          arvalid_d    = 1'b1;
          state_d      = ADDR;
`ifdef ARB_RR_EN
          last_grant_d = grant_d;
`endif
        end
      end
      ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        // Stray beats (other IDs) are consumed by rready and simply not forwarded.
        if (beat_match && rlast) begin
          rready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      arid_q       <= 4'd0;
      araddr_q     <= 32'd0;
      arlen_q      <= 8'd0;
      owner_is_d_q <= 1'b0;
`ifdef ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      owner_is_d_q <= owner_is_d_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_rd_arbiter;

  localparam logic [3:0] I_ID = 4'd0;
  localparam logic [3:0] D_ID = 4'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic [7:0]  i_len, d_len;
  logic        i_ack, i_rvalid, i_rlast;
  logic        d_ack, d_rvalid, d_rlast;
  logic [31:0] rdata_o;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  mem_rd_arbiter #(.I_ID(I_ID), .D_ID(D_ID)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_ack(i_ack),
    .i_rvalid(i_rvalid), .i_rlast(i_rlast),
    .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_ack(d_ack),
    .d_rvalid(d_rvalid), .d_rlast(d_rlast), .rdata_o(rdata_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- logs of observed transactions ----------------
  logic [31:0] ack_log[$], arid_log[$], i_beats[$], d_beats[$];
  int          ack_cyc[$], hs_cyc[$], beat_cyc[$], rlast_cyc[$];
  logic [31:0] exp_q[$], got_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_q(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk(name, got_q[k], exp_q[k]);
  endtask

  task automatic clear_logs();
    ack_log.delete(); arid_log.delete(); i_beats.delete(); d_beats.delete();
    ack_cyc.delete(); hs_cyc.delete(); beat_cyc.delete(); rlast_cyc.delete();
  endtask

  // ---------------- behavioural model ----------------
  // stage: 0 = free, 1 = address offered, 2 = data returning
  bit          m_on = 1'b0;
  int          m_stage = 0;
  bit          m_own_d;
  bit          m_last_d = 1'b1;
  logic [3:0]  m_id;
  logic [31:0] m_addr;
  logic [7:0]  m_len;

  function automatic bit model_pick_d();
`ifdef ARB_RR_EN
    return d_req && (!i_req || !m_last_d);
`else
    return d_req;
`endif
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_on = 1'b1;
      m_stage = 0;
      m_last_d = 1'b1;
    end else begin
      case (m_stage)
        0: if (d_req || i_req) begin
          m_own_d  = model_pick_d();
          m_last_d = m_own_d;
          m_id     = m_own_d ? D_ID : I_ID;
          m_addr   = m_own_d ? d_addr : i_addr;
          m_len    = m_own_d ? d_len : i_len;
          m_stage  = 1;
        end
        1: if (arready) m_stage = 2;
        default: if (rvalid && rid == m_id && rlast) m_stage = 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit gd, gi, mt;
    if (m_on) begin
      gd = (m_stage == 0) && model_pick_d();
      gi = (m_stage == 0) && i_req && !model_pick_d();
      mt = (m_stage == 2) && rvalid && (rid == m_id);
      chk("i_ack", i_ack, gi);
      chk("d_ack", d_ack, gd);
      chk("arvalid", arvalid, m_stage == 1);
      chk("rready", rready, m_stage == 2);
      chk("i_rvalid", i_rvalid, mt && !m_own_d);
      chk("d_rvalid", d_rvalid, mt && m_own_d);
      chk("i_rlast", i_rlast, mt && !m_own_d && rlast);
      chk("d_rlast", d_rlast, mt && m_own_d && rlast);
      chk("arsize", arsize, 3'b010);
      chk("arburst", arburst, 2'b01);
      if (m_stage == 1) begin
        chk("araddr", araddr, m_addr);
        chk("arid", arid, m_id);
        chk("arlen", arlen, m_len);
      end
      if (mt) chk("rdata_o", rdata_o, rdata);
    end
    if (i_ack) begin ack_log.push_back(0); ack_cyc.push_back(cyc); end
    if (d_ack) begin ack_log.push_back(1); ack_cyc.push_back(cyc); end
    if (arvalid && arready) begin arid_log.push_back(arid); hs_cyc.push_back(cyc); end
    if (i_rvalid) i_beats.push_back(rdata_o);
    if (d_rvalid) d_beats.push_back(rdata_o);
    if (i_rvalid || d_rvalid) beat_cyc.push_back(cyc);
    if (i_rlast || d_rlast) rlast_cyc.push_back(cyc);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic req_i(input logic [31:0] a, input logic [7:0] l);
    bit got = 1'b0;
    i_req = 1'b1; i_addr = a; i_len = l;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = i_ack;
    end
    if (!got) chk("i_ack_timeout", 0, 1);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic req_d(input logic [31:0] a, input logic [7:0] l);
    bit got = 1'b0;
    d_req = 1'b1; d_addr = a; d_len = l;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = d_ack;
    end
    if (!got) chk("d_ack_timeout", 0, 1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  // Waits for the data phase, optionally injects one stray rid=2 beat, then n owner beats.
  task automatic serve(input logic [3:0] id, input int n, input logic [31:0] base, input bit stray);
    int t = 0;
    while (!rready && t < 300) begin @(posedge clk); #1; t++; end
    if (!rready) chk("rready_timeout", 0, 1);
    if (stray) begin
      rvalid = 1'b1; rid = 4'd2; rdata = 32'hdead_beef; rlast = 1'b1;
      @(posedge clk); #1;
    end
    for (int k = 0; k < n; k++) begin
      rvalid = 1'b1; rid = id; rdata = 32'(base * (k + 1)); rlast = (k == n - 1);
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1; i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; i_len = 0; d_len = 0;
    arready = 1'b1; rid = 0; rdata = 0; rresp = 2'b10; rlast = 0; rvalid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_arid", arid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_acks", {i_ack, d_ack}, 0);
    @(posedge clk); #1;

    // single i-side burst of 4 beats
    clear_logs();
    req_i(32'h1c00_0000, 8'd3);
    serve(I_ID, 4, 32'h11, 1'b0);
    exp_q = {32'h11, 32'h22, 32'h33, 32'h44}; got_q = i_beats; chk_q("t1_i_beats");
    chk("t1_d_beats", d_beats.size(), 0);
    chk("t1_arid", arid_log[0], 0);
    chk("t1_araddr_latched", araddr, 32'h1c00_0000);
    chk("t1_arlen_latched", arlen, 8'd3);
    chk("t1_ack_to_ar", hs_cyc[0] - ack_cyc[0], 1);
    chk("t1_ack_to_data", beat_cyc[0] - ack_cyc[0], 2);
    chk("t1_rlast_count", rlast_cyc.size(), 1);

    // simultaneous requests
    do_reset();
    fork
      req_i(32'h1c00_0100, 8'd1);
      req_d(32'h8000_1000, 8'd1);
      begin
`ifdef ARB_RR_EN
        serve(I_ID, 2, 32'h200, 1'b0);
        serve(D_ID, 2, 32'h100, 1'b0);
`else
        serve(D_ID, 2, 32'h100, 1'b0);
        serve(I_ID, 2, 32'h200, 1'b0);
`endif
      end
    join
`ifdef ARB_RR_EN
    exp_q = {32'd0, 32'd1};
`else
    exp_q = {32'd1, 32'd0};
`endif
    got_q = ack_log;  chk_q("t2_grant_order");
    got_q = arid_log; chk_q("t2_arid_order");
    exp_q = {32'h100, 32'h200}; got_q = d_beats; chk_q("t2_d_beats");
    exp_q = {32'h200, 32'h400}; got_q = i_beats; chk_q("t2_i_beats");
    chk("t2_rlast_to_ack", ack_cyc[1] - rlast_cyc[0], 1);

`ifdef ARB_RR_EN
    // continuous contention alternates from i
    do_reset();
    fork
      repeat (2) req_i(32'h1c00_0400, 8'd0);
      repeat (2) req_d(32'h8000_0400, 8'd0);
      begin
        serve(I_ID, 1, 32'h31, 1'b0);
        serve(D_ID, 1, 32'h41, 1'b0);
        serve(I_ID, 1, 32'h51, 1'b0);
        serve(D_ID, 1, 32'h61, 1'b0);
      end
    join
    exp_q = {32'd0, 32'd1, 32'd0, 32'd1}; got_q = ack_log; chk_q("t3_rr_order");
`endif

    // AR back-pressure for 5 cycles
    do_reset();
    arready = 1'b0;
    req_d(32'h8000_2000, 8'd2);
    i_req = 1'b1; i_addr = 32'h1c00_0500; i_len = 8'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_arvalid", arvalid, 1);
      chk("t4_araddr", araddr, 32'h8000_2000);
      chk("t4_arlen", arlen, 8'd2);
      chk("t4_arid", arid, D_ID);
      chk("t4_no_ack", {i_ack, d_ack}, 0);
      chk("t4_rready", rready, 0);
      @(posedge clk); #1;
    end
    arready = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    chk("t4_arvalid_hs", arvalid, 1);
    @(posedge clk); #1;
    chk("t4_data_rready", rready, 1);
    chk("t4_arvalid_drop", arvalid, 0);
    serve(D_ID, 3, 32'h300, 1'b0);
    exp_q = {32'h300, 32'h600, 32'h900}; got_q = d_beats; chk_q("t4_d_beats");

    // stray beat with foreign id
    do_reset();
    req_i(32'h1c00_0200, 8'd1);
    serve(I_ID, 2, 32'h500, 1'b1);
    exp_q = {32'h500, 32'ha00}; got_q = i_beats; chk_q("t5_i_beats");
    chk("t5_d_beats", d_beats.size(), 0);

    // reset on the 2nd beat of an 8-beat burst
    do_reset();
    req_d(32'h8000_3000, 8'd7);
    while (!rready && cyc < 90000) begin @(posedge clk); #1; end
    rvalid = 1'b1; rid = D_ID; rdata = 32'h600; rlast = 1'b0;
    @(posedge clk); #1;
    rdata = 32'hc00; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rdata = 32'h1200;
    chk("t6_rready", rready, 0);
    chk("t6_arvalid", arvalid, 0);
    chk("t6_araddr", araddr, 0);
    i_req = 1'b1; i_addr = 32'h1c00_0300; i_len = 8'd0;
    @(negedge clk);
    chk("t6_i_ack", i_ack, 1);
    chk("t6_no_fwd", {i_rvalid, d_rvalid}, 0);
    @(posedge clk); #1;
    i_req = 1'b0; rvalid = 1'b0;
    serve(I_ID, 1, 32'h700, 1'b0);
    exp_q = {32'h600, 32'hc00}; got_q = d_beats; chk_q("t6_d_beats");
    exp_q = {32'h700};          got_q = i_beats; chk_q("t6_i_beats");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
